reg_write_sequencer: RTL
========================

# reg_write_sequencer

Write-side initiator for the processor's register bank. Accepts write requests from the datapath (ALU result, MUL/DIV pair, delay preset, RF result, stack push/pop), buffers them in a small FIFO and issues them one per cycle as the bank's 8-bit control word plus write index and write data. It also reports read-after-write hazards against still-queued writes to the control unit.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- clk  in  1  system clock; outputs registered on rising edge, bank consumes on falling edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full; transfer when valid & ready at rising edge
- req_kind  in  3  0 NOP, 1 REG, 2 MULDIV, 3 PTIME, 4 RF, 5 PUSH, 6 POP, 7 reserved
- req_reg  in  5  destination register (REG only)
- req_data0  in  32  REG/PTIME/RF data; LO for MULDIV
- req_data1  in  32  HI for MULDIV; ignored otherwise
- hold  in  1  bank busy; suppress issue
- flush  in  1  discard all queued entries
- rd_idx0, rd_idx1  in  5 each  registers the control unit is about to read
- hazard  out  1  a queued REG write targets a nonzero rd_idx
- ctrl  out  8  bank control word
- RE0  out  5  write index
- esc0, esc1  out  32 each  write data
- busy  out  1  FIFO non-empty or command on outputs

## Operation
- Control word per kind: REG 8'h21, MULDIV 8'hC0, PTIME 8'hC3, RF 8'hE0, PUSH 8'h18 (SP−4), POP 8'h08 (SP+4); idle 8'h00.
- Reset: ctrl 8'h00, RE0 0, esc0/esc1 0, FIFO empty, req_ready 1, hazard 0, busy 0, state IDLE.
- Dropped at enqueue (accepted, ready honoured, never queued): kind NOP, kind 7, REG with req_reg==0.
- States: IDLE (FIFO empty, outputs idle); RUN (issuing head each cycle); HELD (hold=1 with FIFO non-empty, outputs idle, no pop). IDLE→RUN on first enqueue; RUN→HELD on hold; HELD→RUN when hold falls; RUN→IDLE when last entry issued and none arriving.
- Each issued command occupies outputs for exactly one cycle; next cycle shows next entry or idle word. Fields not used by a kind are driven 0.
- req_ready = ~full, registered from count; no same-cycle credit from a pop when full.
- flush: FIFO emptied and outputs forced idle at the next edge; flush has priority over a simultaneous enqueue (that request is lost, ready still 1). State → IDLE.
- hazard: combinational OR over valid FIFO entries of kind REG whose reg equals rd_idx0 or rd_idx1 (index 0 never matches). The entry on the output stage does not count: bank writes it on the falling edge, before the next read.
- Order strictly FIFO; no merging or reordering.

## Timing
- Request accepted at rising edge N, FIFO empty, hold=0: command on outputs after edge N+1, written by bank at falling edge in cycle N+1. Latency 1 cycle.
- Throughput one command per cycle; full-rate streaming with DEPTH entries never deasserts ready when issue is continuous.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- hold sampled at rising edge; asserting it leaves outputs idle from that edge on.
- Reset mid-burst discards all entries immediately (asynchronous).

## Configuration
- REGWR_HAZARD_EN defined: hazard comparator over all entries compiled in as above.
- Not defined: comparator omitted, hazard tied 0; control unit must then wait on busy=0 before dependent reads.

## Structure
- Package regwr_pkg: kind enum, control-word constants (mode codes LDREG/LDMULDIV/LDRF, bit positions EscReg1/EscReg2/Pilha1/Pilha2/EmpDesemp), entry struct {kind, reg, data0, data1}.
- Sub-module regwr_fifo: parameterised synchronous FIFO of entries exposing full, empty, head and the entry array for hazard comparison.
- Top holds state machine, enqueue filter, output register.

## Test plan
- Single REG write r5=32'hDEADBEEF at edge 0 -> edge 1: ctrl 8'h21, RE0 5, esc0 DEADBEEF; edge 2: ctrl 8'h00, busy 0.
- MULDIV LO=7, HI=9 then PUSH back-to-back -> consecutive cycles ctrl C0 (esc0 7, esc1 9), then 18.
- hold=1, enqueue 5 requests (DEPTH 4) -> req_ready low after 4th, outputs idle; release hold -> 4 commands in order on 4 consecutive cycles, then 5th.
- Queue REG r3, rd_idx0=3 -> hazard 1 until that entry reaches outputs, 0 after; rd_idx1=0 with REG r0 request -> dropped, hazard 0.
- 3 entries queued, flush with simultaneous valid request -> next edge FIFO empty, ctrl 00, busy 0, request not issued.
- Assert reset mid-stream -> outputs 0, ready 1 immediately; first request after release issues with 1-cycle latency.

Source files
------------

// File: rtl/regwr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regwr_pkg
// Description : Request kinds, bank control-word encoding and queued entry
//               type shared by the register write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regwr_pkg;

    typedef enum logic [2:0] {
        KIND_NOP    = 3'd0,
        KIND_REG    = 3'd1,
        KIND_MULDIV = 3'd2,
        KIND_PTIME  = 3'd3,
        KIND_RF     = 3'd4,
        KIND_PUSH   = 3'd5,
        KIND_POP    = 3'd6,
        KIND_RSVD   = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HELD = 2'd2
    } state_e;

    // Mode field occupies ctrl[7:5]; remaining bits are individual strobes.
    localparam logic [2:0] LDREG    = 3'b001;
    localparam logic [2:0] LDMULDIV = 3'b110;
    localparam logic [2:0] LDRF     = 3'b111;

    localparam int ESCREG1   = 0;
    localparam int ESCREG2   = 1;
    localparam int PILHA2    = 2;
    localparam int EMPDESEMP = 3;
    localparam int PILHA1    = 4;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  dst;
        logic [31:0] data0;
        logic [31:0] data1;
    } entry_t;

    function automatic logic [7:0] ctrl_word(input kind_e k);
        logic [7:0] w;
        w = 8'h00;
        case (k)
            KIND_REG: begin
                w[7:5]     = LDREG;
                w[ESCREG1] = 1'b1;
            end
            KIND_MULDIV: w[7:5] = LDMULDIV;
            KIND_PTIME: begin
                w[7:5]     = LDMULDIV;
                w[ESCREG1] = 1'b1;
                w[ESCREG2] = 1'b1;
            end
            KIND_RF: w[7:5] = LDRF;
            KIND_PUSH: begin
                w[PILHA1]    = 1'b1;
                w[EMPDESEMP] = 1'b1;
            end
            KIND_POP: w[EMPDESEMP] = 1'b1;
            default: w = 8'h00;
        endcase
        return w;
    endfunction

    // NOP, reserved kind and writes to r0 are accepted but never queued.
    function automatic logic entry_kept(input kind_e k, input logic [4:0] dst);
        logic keep;
        keep = 1'b0;
        case (k)
            KIND_REG:                                            keep = (dst != 5'd0);
            KIND_MULDIV, KIND_PTIME, KIND_RF, KIND_PUSH, KIND_POP: keep = 1'b1;
            default:                                             keep = 1'b0;
        endcase
        return keep;
    endfunction

    function automatic logic uses_data0(input kind_e k);
        return (k == KIND_REG) || (k == KIND_MULDIV) || (k == KIND_PTIME) || (k == KIND_RF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_sequencer_if
// Description : Request, bank-output and hazard signals of the register
//               write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  req_reg;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic        hold;
    logic        flush;
    logic [4:0]  rd_idx0;
    logic [4:0]  rd_idx1;
    logic        hazard;
    logic [7:0]  ctrl;
    logic [4:0]  RE0;
    logic [31:0] esc0;
    logic [31:0] esc1;
    logic        busy;

    modport master (
        output req_valid, req_kind, req_reg, req_data0, req_data1,
        output hold, flush, rd_idx0, rd_idx1,
        input  req_ready, hazard, ctrl, RE0, esc0, esc1, busy
    );

    modport slave (
        input  req_valid, req_kind, req_reg, req_data0, req_data1,
        input  hold, flush, rd_idx0, rd_idx1,
        output req_ready, hazard, ctrl, RE0, esc0, esc1, busy
    );
endinterface
`default_nettype wire

// File: rtl/regwr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : regwr_fifo
// Description : Synchronous FIFO of write entries; exposes the full entry
//               array and a per-slot valid mask for hazard comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module regwr_fifo
    import regwr_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   i_flush,
    input  wire logic                   i_push,
    input  entry_t                      i_entry,
    input  wire logic                   i_pop,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count,
    output entry_t                      o_head,
    output entry_t                      o_entries [DEPTH],
    output logic [DEPTH-1:0]            o_valid
);

    localparam int AW = $clog2(DEPTH);

    entry_t         r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_entry;
    end

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign o_entries = r_mem;

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [AW-1:0] w_off;
        assign w_off      = AW'(i) - r_rptr;
        assign o_valid[i] = ({1'b0, w_off} < r_count);
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_sequencer
// Description : Queues datapath write requests and issues one bank command
//               per cycle. Optional hazard comparator: REGWR_HAZARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_sequencer
    import regwr_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  wire logic              clk,
    input  wire logic              reset,
    reg_write_sequencer_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e           r_state;
    state_e           w_state_next;
    logic [7:0]       r_ctrl;
    logic [4:0]       r_re0;
    logic [31:0]      r_esc0;
    logic [31:0]      r_esc1;
    logic             r_out_valid;

    logic [7:0]       w_ctrl_d;
    logic [4:0]       w_re0_d;
    logic [31:0]      w_esc0_d;
    logic [31:0]      w_esc1_d;

    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_left;
    entry_t           w_head;
    entry_t           w_entries [DEPTH];
    logic [DEPTH-1:0] w_valid;
    entry_t           w_new;
    logic             w_push;
    logic             w_pop;

    assign w_new.kind  = kind_e'(bus.req_kind);
    assign w_new.dst   = bus.req_reg;
    assign w_new.data0 = bus.req_data0;
    assign w_new.data1 = bus.req_data1;

    // Flush wins over a simultaneous enqueue; the request is silently lost.
    assign w_push = bus.req_valid && !w_full && !bus.flush
                    && entry_kept(w_new.kind, w_new.dst);
    assign w_pop  = !bus.flush && !bus.hold && !w_empty;
    assign w_left = w_count - {{(CW-1){1'b0}}, w_pop} + {{(CW-1){1'b0}}, w_push};

    regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_flush   (bus.flush),
        .i_push    (w_push),
        .i_entry   (w_new),
        .i_pop     (w_pop),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    always_comb begin
        w_state_next = r_state;
        w_ctrl_d     = 8'h00;
        w_re0_d      = 5'd0;
        w_esc0_d     = 32'd0;
        w_esc1_d     = 32'd0;
        if (w_pop) begin
            w_ctrl_d = ctrl_word(w_head.kind);
            if (w_head.kind == KIND_REG)    w_re0_d  = w_head.dst;
            if (uses_data0(w_head.kind))    w_esc0_d = w_head.data0;
            if (w_head.kind == KIND_MULDIV) w_esc1_d = w_head.data1;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_push) w_state_next = bus.hold ? ST_HELD : ST_RUN;
            end
            ST_RUN: begin
                if (bus.flush || (w_left == '0)) w_state_next = ST_IDLE;
                else if (bus.hold)               w_state_next = ST_HELD;
            end
            ST_HELD: begin
                if (bus.flush || (w_left == '0)) w_state_next = ST_IDLE;
                else if (!bus.hold)              w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ctrl      <= 8'h00;
            r_re0       <= 5'd0;
            r_esc0      <= 32'd0;
            r_esc1      <= 32'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ctrl      <= w_ctrl_d;
            r_re0       <= w_re0_d;
            r_esc0      <= w_esc0_d;
            r_esc1      <= w_esc1_d;
            r_out_valid <= w_pop;
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.ctrl      = r_ctrl;
    assign bus.RE0       = r_re0;
    assign bus.esc0      = r_esc0;
    assign bus.esc1      = r_esc1;
    assign bus.busy      = !w_empty || r_out_valid;

`ifdef REGWR_HAZARD_EN
    // The output-stage entry is already popped, so it never raises hazard.
    logic [DEPTH-1:0] w_hit;
    for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
        assign w_hit[i] = w_valid[i] && (w_entries[i].kind == KIND_REG)
                          && (w_entries[i].dst != 5'd0)
                          && ((w_entries[i].dst == bus.rd_idx0) || (w_entries[i].dst == bus.rd_idx1));
    end
    assign bus.hazard = |w_hit;
`else
    logic [DEPTH-1:0] w_unused_bits;
    logic             w_unused;
    for (genvar i = 0; i < DEPTH; i++) begin : g_unused
        assign w_unused_bits[i] = ^{w_valid[i], w_entries[i]};
    end
    assign w_unused   = ^{w_unused_bits, bus.rd_idx0, bus.rd_idx1};
    assign bus.hazard = 1'b0;
`endif

endmodule
`default_nettype wire
